// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS CPU: reset PC, fetch FSM
// state encoding and next-PC source selection.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef enum logic [2:0] {
    NPC_SEQ  = 3'd0,
    NPC_BR   = 3'd1,
    NPC_J    = 3'd2,
    NPC_JR   = 3'd3,
    NPC_HOLD = 3'd4
  } npc_sel_t;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC register, next-PC selection and syscall halt/resume FSM feeding the
// asynchronous instruction ROM, plus the cycle/branch statistics counters.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [15:0]           branch_offset,
  input  logic                  jump,
  input  logic [25:0]           jump_target,
  input  logic                  jump_reg,
  input  logic [31:0]           reg_target,
  input  logic                  halt_req,
  input  logic                  go,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [31:0]           pc,
  output logic [31:0]           pc_plus4,
  output logic                  halted,
  output logic [31:0]           cycle_count,
  output logic [31:0]           uncond_count,
  output logic [31:0]           cond_count
);

  fetch_state_t state, state_nxt;
  npc_sel_t     npc_sel;
  logic [31:0]  pc_nxt;
  logic         cyc_inc, unc_inc, cond_inc;

  assign pc_plus4 = pc + 32'd4;
  assign rom_addr = pc[ADDR_WIDTH+1:2];
  assign instr    = rom_data;
  assign halted   = (state == HALTED);

  // Every decision is gated by en so a stalled divided clock freezes everything.
  always_comb begin
    state_nxt = state;
    npc_sel   = NPC_HOLD;
    cyc_inc   = 1'b0;
    unc_inc   = 1'b0;
    cond_inc  = 1'b0;
    if (en) begin
      case (state)
        RUN: begin
          cyc_inc = 1'b1;
          if (halt_req) begin
            state_nxt = HALTED;
          end else if (stall) begin
            npc_sel = NPC_HOLD;
          end else if (jump_reg) begin
            npc_sel = NPC_JR;
            unc_inc = 1'b1;
          end else if (jump) begin
            npc_sel = NPC_J;
            unc_inc = 1'b1;
          end else if (branch_taken) begin
            npc_sel  = NPC_BR;
            cond_inc = 1'b1;
          end else begin
            npc_sel = NPC_SEQ;
          end
        end
        HALTED: begin
          if (go) begin
            state_nxt = RUN;
            npc_sel   = NPC_SEQ;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    pc_nxt = pc;
    case (npc_sel)
      NPC_SEQ:  pc_nxt = pc_plus4;
      NPC_BR:   pc_nxt = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
      NPC_J:    pc_nxt = {pc_plus4[31:28], jump_target, 2'b00};
      NPC_JR:   pc_nxt = {reg_target[31:2], 2'b00};
      default:  pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  sat_counter32 u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cyc_inc),
    .count (cycle_count)
  );

  sat_counter32 u_uncond_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (unc_inc),
    .count (uncond_count)
  );

  sat_counter32 u_cond_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cond_inc),
    .count (cond_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed vector bench for instr_fetch_unit: table of single-step vectors
// with hand-computed results, plus en=0 and asynchronous-reset sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, stall = 1'b0, branch_taken = 1'b0;
  logic [15:0] branch_offset = '0;
  logic        jump = 1'b0, jump_reg = 1'b0, halt_req = 1'b0, go = 1'b0;
  logic [25:0] jump_target = '0;
  logic [31:0] reg_target = '0;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data, instr, pc, pc_plus4;
  logic        halted;
  logic [31:0] cycle_count, uncond_count, cond_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_data = {22'h2A5A5, rom_addr} ^ 32'h0F0F_0000;

  instr_fetch_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_target  (jump_target),
    .jump_reg     (jump_reg),
    .reg_target   (reg_target),
    .halt_req     (halt_req),
    .go           (go),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .instr        (instr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .halted       (halted),
    .cycle_count  (cycle_count),
    .uncond_count (uncond_count),
    .cond_count   (cond_count)
  );

  typedef struct {
    logic        en, stall, br;
    logic [15:0] off;
    logic        j;
    logic [25:0] jt;
    logic        jr;
    logic [31:0] rt;
    logic        hr, go;
    logic [31:0] e_pc;
    logic        e_halt;
    logic [31:0] e_cyc, e_unc, e_cond;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic e, logic s, logic b, logic [15:0] o, logic jj,
                              logic [25:0] t, logic r, logic [31:0] rv, logic h, logic g,
                              logic [31:0] p, logic hl, logic [31:0] c, logic [31:0] u,
                              logic [31:0] cd);
    vec_t v;
    v.en = e; v.stall = s; v.br = b; v.off = o; v.j = jj; v.jt = t; v.jr = r;
    v.rt = rv; v.hr = h; v.go = g; v.e_pc = p; v.e_halt = hl; v.e_cyc = c;
    v.e_unc = u; v.e_cond = cd;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [31:0] e_pc, logic e_halt, logic [31:0] e_cyc,
                         logic [31:0] e_unc, logic [31:0] e_cond);
    logic [31:0] e_rom;
    e_rom = {22'h2A5A5, e_pc[11:2]} ^ 32'h0F0F_0000;
    chk({tag, " pc"}, pc, e_pc);
    chk({tag, " rom_addr"}, {22'h0, rom_addr}, {22'h0, e_pc[11:2]});
    chk({tag, " instr"}, instr, e_rom);
    chk({tag, " pc_plus4"}, pc_plus4, e_pc + 32'd4);
    chk({tag, " halted"}, {31'h0, halted}, {31'h0, e_halt});
    chk({tag, " cycle_count"}, cycle_count, e_cyc);
    chk({tag, " uncond_count"}, uncond_count, e_unc);
    chk({tag, " cond_count"}, cond_count, e_cond);
  endtask

  task automatic apply(vec_t v);
    en = v.en; stall = v.stall; branch_taken = v.br; branch_offset = v.off;
    jump = v.j; jump_target = v.jt; jump_reg = v.jr; reg_target = v.rt;
    halt_req = v.hr; go = v.go;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // en st br off      j  jt       jr rt            hr go  pc            h  cyc u  c
    vq.push_back(mk(1,0,0,16'h0,   0,26'h0,  0,32'h0,        0,0, 32'h4,        0, 1, 0,0));
    vq.push_back(mk(1,0,0,16'h0,   0,26'h0,  0,32'h0,        0,0, 32'h8,        0, 2, 0,0));
    vq.push_back(mk(1,0,0,16'h0,   0,26'h0,  0,32'h0,        0,0, 32'hC,        0, 3, 0,0));
    vq.push_back(mk(1,0,0,16'h0,   0,26'h0,  0,32'h0,        0,0, 32'h10,       0, 4, 0,0));
    vq.push_back(mk(1,0,0,16'h0,   0,26'h0,  1,32'h40,       0,0, 32'h40,       0, 5, 1,0));
    vq.push_back(mk(1,0,1,16'hFFFE,0,26'h0,  0,32'h0,        0,0, 32'h3C,       0, 6, 1,1));
    vq.push_back(mk(1,0,0,16'h0,   0,26'h0,  1,32'h40,       0,0, 32'h40,       0, 7, 2,1));
    vq.push_back(mk(1,1,1,16'hFFFE,0,26'h0,  0,32'h0,        0,0, 32'h40,       0, 8, 2,1));
    vq.push_back(mk(1,0,0,16'h0,   0,26'h0,  1,32'h10000010, 0,0, 32'h10000010, 0, 9, 3,1));
    vq.push_back(mk(1,0,0,16'h0,   1,26'h100,0,32'h0,        0,0, 32'h10000400, 0,10, 4,1));
    vq.push_back(mk(1,0,0,16'h0,   0,26'h0,  1,32'h10000010, 0,0, 32'h10000010, 0,11, 5,1));
    vq.push_back(mk(1,0,0,16'h0,   1,26'h100,1,32'h203,      0,0, 32'h200,      0,12, 6,1));
    vq.push_back(mk(1,0,0,16'h0,   0,26'h0,  1,32'h20,       0,0, 32'h20,       0,13, 7,1));
    vq.push_back(mk(1,0,1,16'h4,   0,26'h0,  0,32'h0,        1,0, 32'h20,       1,14, 7,1));
    vq.push_back(mk(1,1,1,16'h4,   1,26'h5,  1,32'h100,      1,0, 32'h20,       1,14, 7,1));
    vq.push_back(mk(1,0,1,16'h4,   1,26'h5,  1,32'h100,      0,0, 32'h20,       1,14, 7,1));
    vq.push_back(mk(1,0,0,16'h0,   0,26'h0,  0,32'h0,        1,0, 32'h20,       1,14, 7,1));
    vq.push_back(mk(1,0,1,16'h4,   0,26'h0,  1,32'h100,      1,1, 32'h24,       0,14, 7,1));
    vq.push_back(mk(0,0,1,16'h4,   1,26'h5,  1,32'h100,      1,0, 32'h24,       0,14, 7,1));
    vq.push_back(mk(1,0,0,16'h0,   0,26'h0,  0,32'h0,        1,1, 32'h24,       1,15, 7,1));
    vq.push_back(mk(1,1,0,16'h0,   0,26'h0,  0,32'h0,        0,1, 32'h28,       0,15, 7,1));
    vq.push_back(mk(1,0,1,16'h7FFF,0,26'h0,  0,32'h0,        0,0, 32'h20028,    0,16, 7,2));
    vq.push_back(mk(1,0,0,16'h0,   0,26'h0,  1,32'hFFFFFFFF, 0,0, 32'hFFFFFFFC, 0,17, 8,2));
    vq.push_back(mk(1,0,0,16'h0,   0,26'h0,  0,32'h0,        0,0, 32'h0,        0,18, 8,2));

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 32'h0, 1'b0, 0, 0, 0);
    rst_n = 1'b1;
    #2;

    foreach (vq[i]) begin
      apply(vq[i]);
      chk_all($sformatf("vec%0d", i), vq[i].e_pc, vq[i].e_halt, vq[i].e_cyc,
              vq[i].e_unc, vq[i].e_cond);
    end

    // en low for many edges with every redirect and halt asserted
    en = 1'b0; stall = 1'b0; branch_taken = 1'b1; branch_offset = 16'h0010;
    jump = 1'b1; jump_target = 26'h3; jump_reg = 1'b1; reg_target = 32'h80;
    halt_req = 1'b1; go = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
    end
    #1;
    chk_all("en_low", 32'h0, 1'b0, 18, 8, 2);

    apply(mk(1,0,0,16'h0,0,26'h0,0,32'h0,0,0, 32'h0,0,0,0,0));
    chk_all("pre_halt", 32'h4, 1'b0, 19, 8, 2);
    apply(mk(1,0,0,16'h0,0,26'h0,0,32'h0,1,0, 32'h0,0,0,0,0));
    chk_all("halt", 32'h4, 1'b1, 20, 8, 2);

    // asynchronous reset while halted, observed well before the next edge
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 32'h0, 1'b0, 0, 0, 0);
    en = 1'b0; halt_req = 1'b0;
    #3;
    rst_n = 1'b1;
    apply(mk(1,0,0,16'h0,0,26'h0,0,32'h0,0,0, 32'h0,0,0,0,0));
    chk_all("after_reset", 32'h4, 1'b0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
